// File: rtl/vector_element_sequencer_if.sv
// Issue, writeback and lane-ALU signals of the vector element sequencer.
// The slave modport is the sequencer; the master modport is the issue/lane side.
interface vector_element_sequencer_if #(
    parameter int VLEN        = 128,
    parameter int LONGEST_LEN = 64,
    parameter int LANE_NUM    = 2,
    parameter int VL_WIDTH    = 5
);
    logic                            start;
    logic [2:0]                      vsew;
    logic [VL_WIDTH-1:0]             vl;
    logic                            vm;
    logic [VLEN-1:0]                 vs1_data;
    logic [VLEN-1:0]                 vs2_data;
    logic [VLEN-1:0]                 vd_old;
    logic [VLEN-1:0]                 v0_data;
    logic [LANE_NUM*LONGEST_LEN-1:0] lane_vs1;
    logic [LANE_NUM*LONGEST_LEN-1:0] lane_vs2;
    logic [LANE_NUM-1:0]             lane_valid;
    logic [LANE_NUM*LONGEST_LEN-1:0] lane_result;
    logic                            busy;
    logic                            done;
    logic [VLEN-1:0]                 vd_data;

    modport slave (
        input  start, vsew, vl, vm, vs1_data, vs2_data, vd_old, v0_data, lane_result,
        output lane_vs1, lane_vs2, lane_valid, busy, done, vd_data
    );

    modport master (
        output start, vsew, vl, vm, vs1_data, vs2_data, vd_old, v0_data, lane_result,
        input  lane_vs1, lane_vs2, lane_valid, busy, done, vd_data
    );
endinterface

// File: rtl/vector_element_sequencer.sv
// Steps one vector instruction through LANE_NUM lane ALUs per cycle, applying
// mask-undisturbed and tail-undisturbed policy, and returns the packed vd.
module vector_element_sequencer #(
    parameter int VLEN        = 128,
    parameter int LONGEST_LEN = 64,
    parameter int LANE_NUM    = 2,
    parameter int VL_WIDTH    = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    vector_element_sequencer_if.slave   bus
);
    localparam int IDX_W = VL_WIDTH + 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                          state_q, state_d;
    logic [VLEN-1:0]                 vs1_q, vs1_d;
    logic [VLEN-1:0]                 vs2_q, vs2_d;
    logic [VLEN-1:0]                 v0_q, v0_d;
    logic [VLEN-1:0]                 buf_q, buf_d;
    logic [VLEN-1:0]                 vd_data_q, vd_data_d;
    logic [1:0]                      sew_q, sew_d;
    logic                            vm_q, vm_d;
    logic [IDX_W-1:0]                vl_q, vl_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;

    logic [LANE_NUM*LONGEST_LEN-1:0] lane_vs1_s;
    logic [LANE_NUM*LONGEST_LEN-1:0] lane_vs2_s;
    logic [LANE_NUM-1:0]             lane_valid_s;
    logic [VLEN-1:0]                 buf_wr_s;
    logic [IDX_W-1:0]                evl_s;

    function automatic logic [IDX_W-1:0] eff_vl(input logic [2:0] sew, input logic [VL_WIDTH-1:0] vl);
        logic [IDX_W-1:0] vlmax;
        logic [IDX_W-1:0] req;
        req = IDX_W'(vl);
        case (sew)
            3'b000:  vlmax = IDX_W'(VLEN / 8);
            3'b001:  vlmax = IDX_W'(VLEN / 16);
            3'b010:  vlmax = IDX_W'(VLEN / 32);
            3'b011:  vlmax = IDX_W'(VLEN / 64);
            default: vlmax = {IDX_W{1'b0}};
        endcase
        eff_vl = (req < vlmax) ? req : vlmax;
    endfunction

    function automatic logic [LONGEST_LEN-1:0] sew_mask(input logic [1:0] sew);
        case (sew)
            2'b00:   sew_mask = LONGEST_LEN'(64'h0000_0000_0000_00FF);
            2'b01:   sew_mask = LONGEST_LEN'(64'h0000_0000_0000_FFFF);
            2'b10:   sew_mask = LONGEST_LEN'(64'h0000_0000_FFFF_FFFF);
            default: sew_mask = LONGEST_LEN'(64'hFFFF_FFFF_FFFF_FFFF);
        endcase
    endfunction

    function automatic logic [15:0] bit_ofs(input logic [IDX_W-1:0] e, input logic [1:0] sew);
        bit_ofs = 16'(e) << (16'd3 + 16'(sew));
    endfunction

    function automatic logic [LONGEST_LEN-1:0] get_elem(input logic [VLEN-1:0] src,
                                                        input logic [IDX_W-1:0] e,
                                                        input logic [1:0] sew);
        get_elem = LONGEST_LEN'(src >> bit_ofs(e, sew)) & sew_mask(sew);
    endfunction

    function automatic logic [VLEN-1:0] put_elem(input logic [VLEN-1:0] dst,
                                                 input logic [IDX_W-1:0] e,
                                                 input logic [1:0] sew,
                                                 input logic [LONGEST_LEN-1:0] val);
        logic [VLEN-1:0] m;
        logic [VLEN-1:0] v;
        m = VLEN'(sew_mask(sew)) << bit_ofs(e, sew);
        v = VLEN'(val & sew_mask(sew)) << bit_ofs(e, sew);
        put_elem = (dst & ~m) | v;
    endfunction

    // Lane operand mux and same-cycle capture of lane results into the buffer.
    always_comb begin : lane_comb
        logic [IDX_W-1:0] e;
        lane_vs1_s   = '0;
        lane_vs2_s   = '0;
        lane_valid_s = '0;
        buf_wr_s     = buf_q;
        e            = {IDX_W{1'b0}};
        for (int k = 0; k < LANE_NUM; k++) begin
            e = idx_q + IDX_W'(k);
            if (state_q == S_RUN && e < vl_q) begin
                lane_vs1_s[k*LONGEST_LEN +: LONGEST_LEN] = get_elem(vs1_q, e, sew_q);
                lane_vs2_s[k*LONGEST_LEN +: LONGEST_LEN] = get_elem(vs2_q, e, sew_q);
                // Masked-off elements stay out of the lanes and keep vd_old.
                if (vm_q || (|(v0_q & (VLEN'(1'b1) << e)))) begin
                    lane_valid_s[k] = 1'b1;
                    buf_wr_s = put_elem(buf_wr_s, e, sew_q,
                                        bus.lane_result[k*LONGEST_LEN +: LONGEST_LEN]);
                end else begin
                    lane_valid_s[k] = 1'b0;
                end
            end else begin
                lane_valid_s[k] = 1'b0;
            end
        end
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d   = state_q;
        vs1_d     = vs1_q;
        vs2_d     = vs2_q;
        v0_d      = v0_q;
        buf_d     = buf_q;
        vd_data_d = vd_data_q;
        sew_d     = sew_q;
        vm_d      = vm_q;
        vl_d      = vl_q;
        idx_d     = idx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        evl_s     = eff_vl(bus.vsew, bus.vl);
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    vs1_d  = bus.vs1_data;
                    vs2_d  = bus.vs2_data;
                    v0_d   = bus.v0_data;
                    buf_d  = bus.vd_old;
                    sew_d  = bus.vsew[1:0];
                    vm_d   = bus.vm;
                    vl_d   = evl_s;
                    idx_d  = {IDX_W{1'b0}};
                    busy_d = 1'b1;
                    if (evl_s == {IDX_W{1'b0}}) begin
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        vd_data_d = bus.vd_old;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end
            S_RUN: begin
                buf_d = buf_wr_s;
                idx_d = idx_q + IDX_W'(LANE_NUM);
                if (idx_q + IDX_W'(LANE_NUM) >= vl_q) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    vd_data_d = buf_wr_s;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers; reset aborts any instruction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            vs1_q     <= '0;
            vs2_q     <= '0;
            v0_q      <= '0;
            buf_q     <= '0;
            vd_data_q <= '0;
            sew_q     <= 2'b00;
            vm_q      <= 1'b0;
            vl_q      <= {IDX_W{1'b0}};
            idx_q     <= {IDX_W{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            vs1_q     <= vs1_d;
            vs2_q     <= vs2_d;
            v0_q      <= v0_d;
            buf_q     <= buf_d;
            vd_data_q <= vd_data_d;
            sew_q     <= sew_d;
            vm_q      <= vm_d;
            vl_q      <= vl_d;
            idx_q     <= idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.lane_vs1   = lane_vs1_s;
    assign bus.lane_vs2   = lane_vs2_s;
    assign bus.lane_valid = lane_valid_s;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.vd_data    = vd_data_q;
endmodule

// File: tb/tb_vector_element_sequencer.sv
// Self-checking bench for vector_element_sequencer: directed scenarios plus
// random instructions compared against a byte-array reference model.
module tb_vector_element_sequencer;
    logic clk;
    logic rst;
    logic alu_op;
    int   checks;
    int   errors;

    vector_element_sequencer_if #(.VLEN(128), .LONGEST_LEN(64), .LANE_NUM(2), .VL_WIDTH(5)) bus ();

    vector_element_sequencer #(.VLEN(128), .LONGEST_LEN(64), .LANE_NUM(2), .VL_WIDTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lane ALUs: add or xor, combinational.
    always_comb begin
        bus.lane_result = '0;
        for (int k = 0; k < 2; k++) begin
            bus.lane_result[k*64 +: 64] = alu_op ? (bus.lane_vs1[k*64 +: 64] ^ bus.lane_vs2[k*64 +: 64])
                                                 : (bus.lane_vs1[k*64 +: 64] + bus.lane_vs2[k*64 +: 64]);
        end
    end

    logic [127:0] exp_vd;
    int           exp_len;
    logic [31:0]  exp_trace;
    logic [127:0] obs_vd;
    int           obs_len;
    logic [31:0]  obs_trace;
    int           obs_done_cyc;
    logic         obs_after_busy;
    logic         obs_after_done;

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [63:0] elem(input logic [127:0] x, input int e, input int sb);
        logic [127:0] s;
        logic [63:0]  r;
        s = x >> (e * sb);
        r = s[63:0];
        if (sb < 64) r = r & ((64'd1 << sb) - 64'd1);
        return r;
    endfunction

    // Reference: vd as 16 bytes, overwritten only for active body elements.
    task automatic model(input logic [2:0] sew, input logic [4:0] vl, input logic vm_i,
                         input logic [127:0] s1, input logic [127:0] s2,
                         input logic [127:0] old, input logic [127:0] m0, input logic op);
        int sb;
        int evl;
        int nb;
        logic [7:0]  bytes [16];
        logic [63:0] v;
        logic        act;
        case (sew)
            3'b000:  sb = 8;
            3'b001:  sb = 16;
            3'b010:  sb = 32;
            3'b011:  sb = 64;
            default: sb = 0;
        endcase
        if (sb == 0) evl = 0;
        else evl = (int'(vl) < 128 / sb) ? int'(vl) : 128 / sb;
        nb = sb / 8;
        for (int i = 0; i < 16; i++) bytes[i] = old[8*i +: 8];
        exp_trace = 32'd0;
        exp_len   = (evl + 1) / 2;
        for (int e = 0; e < evl; e++) begin
            act = vm_i || m0[e];
            exp_trace[e] = act;
            if (act) begin
                v = op ? (elem(s1, e, sb) ^ elem(s2, e, sb)) : (elem(s1, e, sb) + elem(s2, e, sb));
                for (int j = 0; j < nb; j++) bytes[e*nb + j] = v[8*j +: 8];
            end
        end
        for (int i = 0; i < 16; i++) exp_vd[8*i +: 8] = bytes[i];
    endtask

    task automatic drive_instr(input logic [2:0] sew, input logic [4:0] vl, input logic vm_i,
                               input logic [127:0] s1, input logic [127:0] s2,
                               input logic [127:0] old, input logic [127:0] m0);
        bus.vsew     = sew;
        bus.vl       = vl;
        bus.vm       = vm_i;
        bus.vs1_data = s1;
        bus.vs2_data = s2;
        bus.vd_old   = old;
        bus.v0_data  = m0;
    endtask

    // Issue one instruction and record what the DUT does until done (bounded).
    task automatic run_instr(input logic [2:0] sew, input logic [4:0] vl, input logic vm_i,
                             input logic [127:0] s1, input logic [127:0] s2,
                             input logic [127:0] old, input logic [127:0] m0);
        drive_instr(sew, vl, vm_i, s1, s2, old, m0);
        model(sew, vl, vm_i, s1, s2, old, m0, alu_op);
        obs_len      = 0;
        obs_trace    = 32'd0;
        obs_done_cyc = -1;
        obs_vd       = 128'd0;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (bus.done === 1'b1) begin
                obs_done_cyc = cyc;
                obs_vd       = bus.vd_data;
                break;
            end
            if (bus.busy === 1'b1 && obs_len < 16) begin
                obs_trace[2*obs_len +: 2] = bus.lane_valid;
                obs_len++;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        obs_after_busy = bus.busy;
        obs_after_done = bus.done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", bus.done); end
        checks++; if (bus.vd_data !== 128'd0) begin errors++; $display("FAIL reset_vd got %h expected 0", bus.vd_data); end
        checks++; if (bus.lane_valid !== 2'b00) begin errors++; $display("FAIL reset_lane_valid got %b expected 00", bus.lane_valid); end
        checks++; if (bus.lane_vs1 !== 128'd0) begin errors++; $display("FAIL reset_lane_vs1 got %h expected 0", bus.lane_vs1); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_byte_unmasked();
        logic [127:0] s1;
        s1 = 128'd0;
        for (int i = 0; i < 16; i++) s1[8*i +: 8] = 8'(i + 1);
        alu_op = 1'b0;
        run_instr(3'b000, 5'd5, 1'b1, s1, {16{8'h10}}, {16{8'hFF}}, 128'd0);
        checks++; if (obs_done_cyc !== 4) begin errors++; $display("FAIL byte_done_cycle got %0d expected 4", obs_done_cyc); end
        checks++; if (obs_len !== 3 || obs_trace[5:0] !== 6'b01_11_11) begin errors++; $display("FAIL byte_lane_valid got len %0d trace %b expected len 3 trace 011111", obs_len, obs_trace[5:0]); end
        checks++; if (obs_vd !== 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FF15_1413_1211) begin errors++; $display("FAIL byte_vd got %h expected ffffffffffffffffffffff1514131211", obs_vd); end
        checks++; if (obs_after_busy !== 1'b0 || obs_after_done !== 1'b0) begin errors++; $display("FAIL byte_after got busy %b done %b expected 0 0", obs_after_busy, obs_after_done); end
    endtask

    task automatic test_masked_word();
        logic [127:0] s1;
        logic [127:0] old;
        logic [127:0] want;
        for (int i = 0; i < 4; i++) s1[32*i +: 32] = 32'(100 + i);
        old  = rand128();
        want = old;
        want[31:0]  = 32'd101;
        want[95:64] = 32'd103;
        alu_op = 1'b0;
        run_instr(3'b010, 5'd4, 1'b0, s1, {4{32'd1}}, old, 128'b0101);
        checks++; if (obs_vd !== want) begin errors++; $display("FAIL masked_vd got %h expected %h", obs_vd, want); end
        checks++; if (obs_len !== 2 || obs_trace[3:0] !== 4'b0101) begin errors++; $display("FAIL masked_lane_valid got len %0d trace %b expected len 2 trace 0101", obs_len, obs_trace[3:0]); end
        checks++; if (obs_done_cyc !== 3) begin errors++; $display("FAIL masked_done_cycle got %0d expected 3", obs_done_cyc); end
    endtask

    task automatic test_clamp();
        alu_op = 1'b0;
        run_instr(3'b011, 5'd16, 1'b1, rand128(), rand128(), rand128(), 128'd0);
        checks++; if (obs_done_cyc !== 2) begin errors++; $display("FAIL clamp_done_cycle got %0d expected 2", obs_done_cyc); end
        checks++; if (obs_len !== 1 || obs_trace[1:0] !== 2'b11) begin errors++; $display("FAIL clamp_lane_valid got len %0d trace %b expected len 1 trace 11", obs_len, obs_trace[1:0]); end
        checks++; if (obs_vd !== exp_vd) begin errors++; $display("FAIL clamp_vd got %h expected %h", obs_vd, exp_vd); end
    endtask

    task automatic test_vl_zero();
        logic [127:0] old;
        old = rand128();
        run_instr(3'b001, 5'd0, 1'b1, rand128(), rand128(), old, rand128());
        checks++; if (obs_done_cyc !== 1) begin errors++; $display("FAIL vl0_done_cycle got %0d expected 1", obs_done_cyc); end
        checks++; if (obs_vd !== old) begin errors++; $display("FAIL vl0_vd got %h expected %h", obs_vd, old); end
        checks++; if (obs_trace !== 32'd0) begin errors++; $display("FAIL vl0_lane_valid got %b expected 0", obs_trace); end
        checks++; if (obs_after_busy !== 1'b0) begin errors++; $display("FAIL vl0_busy_drop got %b expected 0", obs_after_busy); end
        old = rand128();
        run_instr(3'b110, 5'd8, 1'b1, rand128(), rand128(), old, rand128());
        checks++; if (obs_done_cyc !== 1 || obs_vd !== old) begin errors++; $display("FAIL bad_sew got cycle %0d vd %h expected cycle 1 vd %h", obs_done_cyc, obs_vd, old); end
    endtask

    task automatic test_random();
        logic [2:0] sew;
        logic [4:0] vl;
        for (int n = 0; n < 30; n++) begin
            sew    = 3'($urandom_range(0, 3));
            vl     = 5'($urandom_range(0, 16));
            alu_op = 1'($urandom_range(0, 1));
            run_instr(sew, vl, 1'($urandom_range(0, 1)), rand128(), rand128(), rand128(), rand128());
            checks++; if (obs_done_cyc !== exp_len + 1) begin errors++; $display("FAIL rand%0d_done_cycle got %0d expected %0d", n, obs_done_cyc, exp_len + 1); end
            checks++; if (obs_vd !== exp_vd) begin errors++; $display("FAIL rand%0d_vd got %h expected %h", n, obs_vd, exp_vd); end
            checks++; if (obs_len !== exp_len || obs_trace !== exp_trace) begin errors++; $display("FAIL rand%0d_lane_valid got len %0d trace %h expected len %0d trace %h", n, obs_len, obs_trace, exp_len, exp_trace); end
        end
    endtask

    task automatic test_reset_mid_run();
        int dones;
        alu_op = 1'b0;
        drive_instr(3'b000, 5'd16, 1'b1, rand128(), rand128(), rand128(), 128'd0);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL midrst_state got busy %b done %b expected 0 0", bus.busy, bus.done); end
        checks++; if (bus.vd_data !== 128'd0) begin errors++; $display("FAIL midrst_vd got %h expected 0", bus.vd_data); end
        checks++; if (bus.lane_valid !== 2'b00) begin errors++; $display("FAIL midrst_lane_valid got %b expected 00", bus.lane_valid); end
        dones = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
            @(posedge clk); #1;
        end
        checks++; if (dones !== 0) begin errors++; $display("FAIL midrst_quiet got %0d active cycles expected 0", dones); end
        run_instr(3'b000, 5'd7, 1'b1, rand128(), rand128(), rand128(), 128'd0);
        checks++; if (obs_done_cyc !== 5 || obs_vd !== exp_vd) begin errors++; $display("FAIL midrst_resume got cycle %0d vd %h expected cycle 5 vd %h", obs_done_cyc, obs_vd, exp_vd); end
    endtask

    task automatic test_start_while_busy();
        logic [127:0] exp_a;
        logic [127:0] vd_a;
        logic [127:0] vd_b;
        int  done_a;
        int  done_b;
        int  len_b;
        logic holding;
        logic release_next;
        alu_op = 1'b0;
        drive_instr(3'b000, 5'd6, 1'b1, rand128(), rand128(), rand128(), 128'd0);
        model(3'b000, 5'd6, 1'b1, bus.vs1_data, bus.vs2_data, bus.vd_old, bus.v0_data, 1'b0);
        exp_a = exp_vd;
        bus.start = 1'b1;
        done_a = -1; done_b = -1; len_b = 0;
        vd_a = 128'd0; vd_b = 128'd0;
        holding = 1'b0; release_next = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) bus.start = 1'b0;
            if (release_next) begin bus.start = 1'b0; release_next = 1'b0; holding = 1'b0; end
            if (cyc == 2) begin
                drive_instr(3'b001, 5'd5, 1'b1, rand128(), rand128(), rand128(), 128'd0);
                model(3'b001, 5'd5, 1'b1, bus.vs1_data, bus.vs2_data, bus.vd_old, bus.v0_data, 1'b0);
                len_b = exp_len;
                bus.start = 1'b1;
                holding = 1'b1;
            end else if (holding && bus.busy === 1'b0) begin
                release_next = 1'b1;
            end
            if (bus.done === 1'b1) begin
                if (done_a < 0) begin done_a = cyc; vd_a = bus.vd_data; end
                else begin done_b = cyc; vd_b = bus.vd_data; break; end
            end
        end
        bus.start = 1'b0;
        checks++; if (done_a !== 4) begin errors++; $display("FAIL busy_first_done got %0d expected 4", done_a); end
        checks++; if (vd_a !== exp_a) begin errors++; $display("FAIL busy_first_vd got %h expected %h", vd_a, exp_a); end
        checks++; if (done_b !== 5 + len_b + 1) begin errors++; $display("FAIL busy_second_done got %0d expected %0d", done_b, 5 + len_b + 1); end
        checks++; if (vd_b !== exp_vd) begin errors++; $display("FAIL busy_second_vd got %h expected %h", vd_b, exp_vd); end
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        alu_op = 1'b0;
        rst = 1'b1;
        bus.start = 1'b0;
        drive_instr(3'b000, 5'd0, 1'b1, 128'd0, 128'd0, 128'd0, 128'd0);
        test_reset();
        test_byte_unmasked();
        test_masked_word();
        test_clamp();
        test_vl_zero();
        test_random();
        test_reset_mid_run();
        test_start_while_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
